// File: rtl/adxl_spi_sequencer.sv
// adxl_spi_sequencer: drives the spi_master transaction port to bring up an
// ADXL345 with a fixed three-write init table, then reads DATAX0..DATAZ1 in
// periodic six-byte bursts and publishes the assembled X/Y/Z samples.
module adxl_spi_sequencer #(
    parameter int REG_W       = 8,
    parameter int SAMPLE_DIV  = 50000,
    parameter int ACK_TIMEOUT = 64,
    parameter int GAP_CYC     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    output logic             spi_request_o,
    output logic             spi_r_w_o,
    output logic [5:0]       spi_addr_o,
    output logic [REG_W-1:0] spi_data_w_o,
    input  logic             spi_ack_i,
    input  logic [REG_W-1:0] spi_data_r_i,
    output logic [15:0]      x_o,
    output logic [15:0]      y_o,
    output logic [15:0]      z_o,
    output logic             sample_valid_o,
    output logic             init_done_o,
    output logic             overrun_o,
    output logic             err_o
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int TO_W  = $clog2(ACK_TIMEOUT);
    localparam int GAP_W = $clog2(GAP_CYC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    // ERR_GAP is the low period after an ack timeout, before re-init or idle.
    typedef enum logic [2:0] {
        S_IDLE, S_INIT_REQ, S_INIT_GAP, S_WAIT,
        S_RD_REQ, S_RD_GAP, S_PUBLISH, S_ERR_GAP
    } state_t;

    state_t            state, state_n;
    logic [2:0]        idx, idx_n;
    logic [DIV_W-1:0]  div_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [REG_W-1:0]  rd_buf [0:5];
    logic              tick, gap_last, to_last, timeout_hit;
    logic              in_req, in_gap;
    logic              fld_r_w;
    logic [5:0]        fld_addr;
    logic [REG_W-1:0]  fld_data;

    assign tick     = init_done_o && (div_cnt == DIV_LAST);
    assign gap_last = (gap_cnt == GAP_LAST);
    assign to_last  = (to_cnt == TO_LAST);
    assign in_req   = (state == S_INIT_REQ) || (state == S_RD_REQ);
    assign in_gap   = (state == S_INIT_GAP) || (state == S_RD_GAP) || (state == S_ERR_GAP);

    // Next-state logic; an ack wins over a timeout landing in the same cycle.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable_i) begin
                    state_n = S_INIT_REQ;
                    idx_n   = 3'd0;
                end
            end
            S_INIT_REQ, S_RD_REQ: begin
                if (spi_ack_i) begin
                    state_n = (state == S_INIT_REQ) ? S_INIT_GAP : S_RD_GAP;
                end else if (to_last) begin
                    state_n     = S_ERR_GAP;
                    timeout_hit = 1'b1;
                end
            end
            S_INIT_GAP: begin
                if (gap_last) begin
                    if (!enable_i) begin
                        state_n = S_IDLE;
                    end else if (idx == 3'd2) begin
                        state_n = S_WAIT;
                    end else begin
                        state_n = S_INIT_REQ;
                        idx_n   = idx + 3'd1;
                    end
                end
            end
            S_WAIT: begin
                if (!enable_i) begin
                    state_n = S_IDLE;
                end else if (tick) begin
                    state_n = S_RD_REQ;
                    idx_n   = 3'd0;
                end
            end
            S_RD_GAP: begin
                if (gap_last) begin
                    if (!enable_i) begin
                        state_n = S_IDLE;
                    end else if (idx == 3'd5) begin
                        state_n = S_PUBLISH;
                    end else begin
                        state_n = S_RD_REQ;
                        idx_n   = idx + 3'd1;
                    end
                end
            end
            S_PUBLISH: state_n = S_WAIT;
            S_ERR_GAP: begin
                if (gap_last) begin
                    if (enable_i) begin
                        state_n = S_INIT_REQ;
                        idx_n   = 3'd0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Transaction fields for the request about to be issued (init table or burst address).
    always_comb begin
        fld_r_w  = 1'b0;
        fld_addr = 6'h00;
        fld_data = '0;
        if (state_n == S_RD_REQ) begin
            fld_r_w  = 1'b1;
            fld_addr = 6'h32 + {3'b000, idx_n};
        end else begin
            case (idx_n)
                3'd0: begin fld_addr = 6'h31; fld_data = REG_W'(8'h4B); end
                3'd1: begin fld_addr = 6'h2C; fld_data = REG_W'(8'h0A); end
                3'd2: begin fld_addr = 6'h2D; fld_data = REG_W'(8'h08); end
                default: begin fld_addr = 6'h00; fld_data = '0; end
            endcase
        end
    end

    // State, counters, handshake registers, byte capture and sample publish.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            idx            <= 3'd0;
            div_cnt        <= '0;
            to_cnt         <= '0;
            gap_cnt        <= '0;
            spi_request_o  <= 1'b0;
            spi_r_w_o      <= 1'b0;
            spi_addr_o     <= 6'h00;
            spi_data_w_o   <= '0;
            x_o            <= 16'h0000;
            y_o            <= 16'h0000;
            z_o            <= 16'h0000;
            sample_valid_o <= 1'b0;
            init_done_o    <= 1'b0;
            overrun_o      <= 1'b0;
            err_o          <= 1'b0;
            for (int i = 0; i < 6; i++) rd_buf[i] <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            gap_cnt <= (in_gap && state_n == state) ? gap_cnt + 1'b1 : '0;
            to_cnt  <= (in_req && state_n == state) ? to_cnt + 1'b1 : '0;

            if (!init_done_o || tick) div_cnt <= '0;
            else                      div_cnt <= div_cnt + 1'b1;

            spi_request_o <= (state_n == S_INIT_REQ) || (state_n == S_RD_REQ);
            if ((state_n == S_INIT_REQ) || (state_n == S_RD_REQ)) begin
                spi_r_w_o    <= fld_r_w;
                spi_addr_o   <= fld_addr;
                spi_data_w_o <= fld_data;
            end

            if (state == S_RD_REQ && spi_ack_i) rd_buf[idx] <= spi_data_r_i;

            sample_valid_o <= (state_n == S_PUBLISH);
            if (state_n == S_PUBLISH) begin
                x_o <= {rd_buf[1], rd_buf[0]};
                y_o <= {rd_buf[3], rd_buf[2]};
                z_o <= {rd_buf[5], rd_buf[4]};
            end

            init_done_o <= (state_n == S_WAIT) || (state_n == S_RD_REQ) ||
                           (state_n == S_RD_GAP) || (state_n == S_PUBLISH);
            if (timeout_hit)              err_o     <= 1'b1;
            if (tick && state != S_WAIT)  overrun_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adxl_spi_sequencer.sv
// tb_adxl_spi_sequencer: drives adxl_spi_sequencer against a small spi_master
// slave model with programmable ack latency and a scoreboard of expected
// transactions and samples.
module tb_adxl_spi_sequencer;

    localparam int SDIV = 100;
    localparam int TOUT = 64;
    localparam int GAP  = 4;

    logic        clk = 1'b0;
    logic        rst, enable, ack;
    logic [7:0]  data_r;
    logic        spi_request_o, spi_r_w_o;
    logic [5:0]  spi_addr_o;
    logic [7:0]  spi_data_w_o;
    logic [15:0] x_o, y_o, z_o;
    logic        sample_valid_o, init_done_o, overrun_o, err_o;

    typedef struct packed { logic rw; logic [5:0] addr; logic [7:0] data; } txn_t;
    typedef struct packed { logic [15:0] x; logic [15:0] y; logic [15:0] z; } smp_t;

    txn_t       exp_q [$];
    smp_t       smp_q [$];
    smp_t       last_smp;
    logic [7:0] rd_bytes [0:5];
    int         ack_lat = 17;
    bit         nack_en = 1'b0;
    logic [5:0] nack_addr = 6'h00;
    int         vectors = 0;
    int         miscompares = 0;

    adxl_spi_sequencer #(.REG_W(8), .SAMPLE_DIV(SDIV), .ACK_TIMEOUT(TOUT), .GAP_CYC(GAP)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .spi_request_o(spi_request_o), .spi_r_w_o(spi_r_w_o), .spi_addr_o(spi_addr_o),
        .spi_data_w_o(spi_data_w_o), .spi_ack_i(ack), .spi_data_r_i(data_r),
        .x_o(x_o), .y_o(y_o), .z_o(z_o), .sample_valid_o(sample_valid_o),
        .init_done_o(init_done_o), .overrun_o(overrun_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Slave model: acks ack_lat cycles after request rises, unless that address is being refused.
    initial begin
        int cyc;
        cyc = 0;
        ack = 1'b0;
        data_r = 8'h00;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (spi_request_o) begin
                cyc++;
                if (cyc == ack_lat && !(nack_en && spi_addr_o == nack_addr)) begin
                    ack = 1'b1;
                    data_r = spi_r_w_o ? rd_bytes[spi_addr_o - 6'h32] : 8'h00;
                end
            end else begin
                cyc = 0;
            end
        end
    end

    // Loads the slave read bytes and pushes the sample they should produce.
    task automatic set_bytes(input logic [7:0] b0, b1, b2, b3, b4, b5);
        rd_bytes[0] = b0; rd_bytes[1] = b1; rd_bytes[2] = b2;
        rd_bytes[3] = b3; rd_bytes[4] = b4; rd_bytes[5] = b5;
        smp_q.push_back({b1, b0, b3, b2, b5, b4});
    endtask

    // Counts low cycles until request rises, then high cycles until it falls.
    task automatic next_txn(input int budget, output bit ok, output txn_t t,
                            output int lo, output int hi, output bit stable);
        ok = 1'b0; lo = 0; hi = 0; stable = 1'b1; t = '0;
        while (!spi_request_o && lo < budget) begin
            lo++;
            @(negedge clk);
        end
        if (spi_request_o) begin
            t = {spi_r_w_o, spi_addr_o, spi_data_w_o};
            while (spi_request_o && hi < budget) begin
                hi++;
                if ({spi_r_w_o, spi_addr_o, spi_data_w_o} !== t) stable = 1'b0;
                @(negedge clk);
            end
            ok = !spi_request_o;
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok, output int cnt);
        cnt = 0;
        while (!sample_valid_o && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        ok = sample_valid_o;
    endtask

    task automatic test_reset();
        vectors++;
        if (spi_request_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_request got %b want 0", spi_request_o);
        end
        vectors++;
        if ({x_o, y_o, z_o} !== 48'h0) begin
            miscompares++; $display("[TB] FAIL reset_xyz got %h want 0", {x_o, y_o, z_o});
        end
        vectors++;
        if ({sample_valid_o, init_done_o, overrun_o, err_o, spi_r_w_o, spi_addr_o, spi_data_w_o} !== '0) begin
            miscompares++; $display("[TB] FAIL reset_flags got %b %b %b %b %h %h want all 0",
                sample_valid_o, init_done_o, overrun_o, err_o, spi_addr_o, spi_data_w_o);
        end
    endtask

    task automatic test_init();
        txn_t got, exp;
        bit ok, stable;
        int lo, hi;
        exp_q.push_back({1'b0, 6'h31, 8'h4B});
        exp_q.push_back({1'b0, 6'h2C, 8'h0A});
        exp_q.push_back({1'b0, 6'h2D, 8'h08});
        ack_lat = 17;
        rst = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_txn(300, ok, got, lo, hi, stable);
            exp = exp_q.pop_front();
            vectors++;
            if (!ok || got !== exp) begin
                miscompares++; $display("[TB] FAIL init_txn%0d got %h ok=%0d want %h", k, got, ok, exp);
            end
            vectors++;
            if (hi !== 17 || !stable) begin
                miscompares++; $display("[TB] FAIL init_req_len%0d got %0d stable=%0d want 17", k, hi, stable);
            end
            if (k > 0) begin
                vectors++;
                if (lo !== GAP) begin
                    miscompares++; $display("[TB] FAIL init_gap%0d got %0d want %0d", k, lo, GAP);
                end
            end
        end
        repeat (GAP - 1) @(negedge clk);
        vectors++;
        if (init_done_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL init_done_early got %b want 0", init_done_o);
        end
        @(negedge clk);
        vectors++;
        if (init_done_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL init_done got %b want 1", init_done_o);
        end
        ack_lat = 3;
    endtask

    task automatic test_sampling();
        txn_t got;
        smp_t exp;
        bit ok, stable;
        int lo, hi, cnt;
        set_bytes(8'h10, 8'h01, 8'hFE, 8'hFF, 8'h00, 8'h80);
        for (int k = 0; k < 6; k++) begin
            next_txn(300, ok, got, lo, hi, stable);
            vectors++;
            if (!ok || got.rw !== 1'b1 || got.addr !== 6'(6'h32 + k) || hi !== 3) begin
                miscompares++; $display("[TB] FAIL read_txn%0d got rw=%b addr=%h len=%0d want rw=1 addr=%h len=3",
                    k, got.rw, got.addr, hi, 6'(6'h32 + k));
            end
            if (k > 0) begin
                vectors++;
                if (lo !== GAP) begin
                    miscompares++; $display("[TB] FAIL read_gap%0d got %0d want %0d", k, lo, GAP);
                end
            end
        end
        wait_valid(50, ok, cnt);
        exp = smp_q.pop_front();
        vectors++;
        if (!ok || cnt !== GAP || {x_o, y_o, z_o} !== exp) begin
            miscompares++; $display("[TB] FAIL sample1 got %h after %0d want %h after %0d", {x_o, y_o, z_o}, cnt, exp, GAP);
        end
        last_smp = exp;
        set_bytes(8'h34, 8'h12, 8'h00, 8'h00, 8'hFF, 8'h7F);
        @(negedge clk);
        vectors++;
        if (sample_valid_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL valid_width got %b want 0", sample_valid_o);
        end
        wait_valid(300, ok, cnt);
        exp = smp_q.pop_front();
        vectors++;
        if (!ok || cnt + 1 !== SDIV) begin
            miscompares++; $display("[TB] FAIL sample_period got %0d want %0d", cnt + 1, SDIV);
        end
        vectors++;
        if ({x_o, y_o, z_o} !== exp || overrun_o !== 1'b0 || err_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL sample2 got %h ovr=%b err=%b want %h ovr=0 err=0",
                {x_o, y_o, z_o}, overrun_o, err_o, exp);
        end
        last_smp = exp;
    endtask

    task automatic test_timeout();
        txn_t got, exp;
        bit ok, stable;
        int lo, hi;
        enable = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ack_lat = 17;
        nack_addr = 6'h2C;
        nack_en = 1'b1;
        exp_q.push_back({1'b0, 6'h31, 8'h4B});
        exp_q.push_back({1'b0, 6'h2C, 8'h0A});
        exp_q.push_back({1'b0, 6'h31, 8'h4B});
        exp_q.push_back({1'b0, 6'h2C, 8'h0A});
        exp_q.push_back({1'b0, 6'h2D, 8'h08});
        rst = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            next_txn(300, ok, got, lo, hi, stable);
            exp = exp_q.pop_front();
            vectors++;
            if (!ok || got !== exp) begin
                miscompares++; $display("[TB] FAIL retry_txn%0d got %h want %h", k, got, exp);
            end
            if (k == 1) begin
                nack_en = 1'b0;
                vectors++;
                if (hi !== TOUT || err_o !== 1'b1 || init_done_o !== 1'b0) begin
                    miscompares++; $display("[TB] FAIL timeout got len=%0d err=%b done=%b want len=%0d err=1 done=0",
                        hi, err_o, init_done_o, TOUT);
                end
            end
            if (k == 2) begin
                vectors++;
                if (lo !== GAP) begin
                    miscompares++; $display("[TB] FAIL timeout_gap got %0d want %0d", lo, GAP);
                end
            end
        end
        repeat (GAP) @(negedge clk);
        vectors++;
        if (init_done_o !== 1'b1 || err_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL reinit got done=%b err=%b want done=1 err=1", init_done_o, err_o);
        end
        ack_lat = 3;
    endtask

    task automatic test_disable();
        txn_t got, exp;
        smp_t sexp;
        bit ok, stable, saw_req, saw_valid;
        int lo, hi, cnt;
        set_bytes(8'h78, 8'h56, 8'h01, 8'h80, 8'hAA, 8'h55);
        wait_valid(300, ok, cnt);
        sexp = smp_q.pop_front();
        vectors++;
        if (!ok || {x_o, y_o, z_o} !== sexp) begin
            miscompares++; $display("[TB] FAIL pre_disable_sample got %h want %h", {x_o, y_o, z_o}, sexp);
        end
        last_smp = sexp;
        rd_bytes[0] = 8'hDE; rd_bytes[1] = 8'hAD; rd_bytes[2] = 8'hBE;
        rd_bytes[3] = 8'hEF; rd_bytes[4] = 8'h11; rd_bytes[5] = 8'h22;
        for (int k = 0; k < 3; k++) next_txn(300, ok, got, lo, hi, stable);
        cnt = 0;
        while (!spi_request_o && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        vectors++;
        if (spi_request_o !== 1'b1 || spi_addr_o !== 6'h35) begin
            miscompares++; $display("[TB] FAIL byte3_req got req=%b addr=%h want req=1 addr=35", spi_request_o, spi_addr_o);
        end
        enable = 1'b0;
        hi = 0;
        while (spi_request_o && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        vectors++;
        if (hi !== 3) begin
            miscompares++; $display("[TB] FAIL disable_completes got len=%0d want 3", hi);
        end
        saw_req = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (spi_request_o) saw_req = 1'b1;
            if (sample_valid_o) saw_valid = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (saw_req || saw_valid || init_done_o !== 1'b0 || {x_o, y_o, z_o} !== last_smp) begin
            miscompares++; $display("[TB] FAIL disable_idle got req=%b valid=%b done=%b xyz=%h want 0 0 0 %h",
                saw_req, saw_valid, init_done_o, {x_o, y_o, z_o}, last_smp);
        end
        exp_q.push_back({1'b0, 6'h31, 8'h4B});
        exp_q.push_back({1'b0, 6'h2C, 8'h0A});
        exp_q.push_back({1'b0, 6'h2D, 8'h08});
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_txn(300, ok, got, lo, hi, stable);
            exp = exp_q.pop_front();
            vectors++;
            if (!ok || got !== exp) begin
                miscompares++; $display("[TB] FAIL rerun_init%0d got %h want %h", k, got, exp);
            end
        end
        repeat (GAP) @(negedge clk);
        vectors++;
        if (init_done_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL rerun_done got %b want 1", init_done_o);
        end
    endtask

    task automatic test_overrun();
        smp_t exp;
        bit ok;
        int cnt;
        vectors++;
        if (overrun_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL overrun_pre got %b want 0", overrun_o);
        end
        ack_lat = 17;
        set_bytes(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
        for (int s = 0; s < 2; s++) begin
            wait_valid(500, ok, cnt);
            exp = smp_q.pop_front();
            vectors++;
            if (!ok || {x_o, y_o, z_o} !== exp) begin
                miscompares++; $display("[TB] FAIL overrun_sample%0d got %h want %h", s, {x_o, y_o, z_o}, exp);
            end
            if (s == 0) set_bytes(8'hF0, 8'h0F, 8'hC3, 8'h3C, 8'h99, 8'h66);
            @(negedge clk);
        end
        vectors++;
        if (overrun_o !== 1'b1 || err_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL overrun_flag got ovr=%b err=%b want 1 1", overrun_o, err_o);
        end
    endtask

    task automatic test_reset_mid();
        txn_t got, exp;
        bit ok, stable, saw_req;
        int lo, hi, cnt;
        cnt = 0;
        while (!spi_request_o && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (spi_request_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL mid_req_setup got %b want 1", spi_request_o);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({spi_request_o, sample_valid_o, init_done_o, overrun_o, err_o} !== 5'b0 || {x_o, y_o, z_o} !== 48'h0) begin
            miscompares++; $display("[TB] FAIL mid_reset got req=%b flags=%b%b%b%b xyz=%h want all 0",
                spi_request_o, sample_valid_o, init_done_o, overrun_o, err_o, {x_o, y_o, z_o});
        end
        enable = 1'b0;
        rst = 1'b0;
        saw_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (spi_request_o) saw_req = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (saw_req) begin
            miscompares++; $display("[TB] FAIL post_reset_idle got request=1 want 0");
        end
        exp_q.push_back({1'b0, 6'h31, 8'h4B});
        enable = 1'b1;
        next_txn(100, ok, got, lo, hi, stable);
        exp = exp_q.pop_front();
        vectors++;
        if (!ok || got !== exp) begin
            miscompares++; $display("[TB] FAIL post_reset_init got %h want %h", got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 6; i++) rd_bytes[i] = 8'h00;
        last_smp = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_init();
        test_sampling();
        test_timeout();
        test_disable();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
